math_wb_arbiter: RTL and testbench
==================================

Name: math_wb_arbiter

Overview:
- Writeback collector at the consuming end of the packed-SIMD integer ALU result interface.
- Accepts the ALU's fixed-latency, non-stallable result stream (channel A) and a variable-latency valid/ready result stream from the multi-cycle math units (channel B).
- Merges both onto the single register-file write port and the ROB completion port, one completion per cycle.
- Buffers channel A in a small FIFO, throttles ALU issue before that FIFO can overflow, and guarantees channel B forward progress.

Parameters:
- DEPTH, 4, channel A FIFO entries (power of two, >= 4).
- SKID, 2, FIFO headroom reserved for ALU ops already in flight when issue_stall_o asserts.
- B_MAX_WAIT, 4, consecutive cycles channel B may lose arbitration before it is forced to win.

Ports:
- core_clock_i  in  1  core clock.
- core_reset_i  in  1  reset; asynchronous, active-high.
- a_result_i  in  32  channel A result data.
- a_rob_i  in  5  channel A ROB id.
- a_dest_i  in  6  channel A physical destination.
- a_valid_i  in  1  channel A completion valid; cannot be stalled.
- a_wb_valid_i  in  1  channel A register write required (dest != 0).
- b_result_i  in  32  channel B result data.
- b_rob_i  in  5  channel B ROB id.
- b_dest_i  in  6  channel B physical destination.
- b_valid_i  in  1  channel B valid.
- b_ready_o  out  1  channel B accepted this cycle.
- issue_stall_o  out  1  block ALU issue.
- overflow_o  out  1  sticky error: a channel A result was dropped.
- rf_wr_en_o  out  1  register-file write enable.
- rf_wr_addr_o  out  6  register-file write address.
- rf_wr_data_o  out  32  register-file write data.
- rob_done_o  out  1  ROB completion strobe.
- rob_id_o  out  5  ROB id being completed.

Behaviour:
- Reset: while core_reset_i is high (asynchronous), every registered output is 0. FIFO pointers, FIFO count, wait counter and overflow_o are also 0. b_ready_o and issue_stall_o are therefore 0.
- FIFO entry fields: {result, rob, dest, wb}.
- a_cand = FIFO non-empty OR a_valid_i. The A candidate is the FIFO head if non-empty; otherwise it is the incoming A result (bypass).
- grant_b = b_valid_i AND (NOT a_cand OR wait == B_MAX_WAIT).
- grant_a = a_cand AND NOT grant_b.
- b_ready_o = grant_b. It is combinational, and a channel B transfer happens when b_valid_i AND b_ready_o.
- Channel B sources hold their fields stable while valid and not ready.
- Channel B write requirement: wb = (b_dest_i != 0).
- Wait counter:
  - Increments when b_valid_i AND NOT grant_b.
  - Clears on grant_b.
  - Holds otherwise.
  - Saturates at B_MAX_WAIT.
- Enqueue: a_valid_i AND NOT (FIFO empty AND grant_a).
- Dequeue: FIFO non-empty AND grant_a.
- Simultaneous enqueue and dequeue leave the count unchanged. Pointers wrap modulo DEPTH.
- Order: channel A completions leave in arrival order. The bypass is used only when the FIFO is empty.
- Overflow: enqueue required while count == DEPTH and no dequeue this cycle. The incoming entry is dropped, overflow_o sets to 1 and stays set until reset, and FIFO contents are unchanged.
- issue_stall_o = (count >= DEPTH - SKID). Combinational from the registered count.
- Output stage: registered, 1-cycle latency from grant.
  - Next cycle: rob_done_o = grant_a OR grant_b.
  - rob_id_o, rf_wr_addr_o and rf_wr_data_o come from the granted source.
  - rf_wr_en_o = granted wb.
  - With no grant, rob_done_o = 0 and rf_wr_en_o = 0. Data fields may hold their old values but are don't-care.
- rf_wr_en_o implies rob_done_o. A completion with wb = 0 gives rob_done_o = 1 and rf_wr_en_o = 0.
- Reset mid-burst: all buffered completions are discarded. No output pulse occurs after reset deasserts until new input arrives.

Test Plan:
- Empty FIFO, single A op (result 0x00001234, dest 5, rob 3, wb 1), b_valid_i = 0 -> next cycle: rf_wr_en_o = 1, rf_wr_addr_o = 5, rf_wr_data_o = 0x00001234, rob_done_o = 1, rob_id_o = 3; FIFO count stays 0.
- A op with dest 0, a_wb_valid_i = 0, rob 7 -> next cycle: rob_done_o = 1, rob_id_o = 7, rf_wr_en_o = 0.
- B alone (result 0xDEADBEEF, dest 9, rob 2) -> b_ready_o = 1 the same cycle; next cycle: write to address 9 with data 0xDEADBEEF, rob_id_o = 2.
- A valid every cycle plus B held valid, B_MAX_WAIT = 4:
  - B is refused for 4 cycles and granted on the 5th.
  - The A result arriving that cycle enqueues, so count = 1.
  - Subsequent A results drain in order (check rob id sequence).
  - b_rob_i stays stable while refused.
- Fill: with A held valid every cycle, force B wins so the FIFO reaches count 2 -> issue_stall_o = 1; after the drain to count 1 -> issue_stall_o = 0.
- Overflow and reset:
  - Preload count = DEPTH, then present A valid with B forced -> overflow_o = 1, the dropped rob id never appears on rob_id_o, and the FIFO contents are intact.
  - Then assert core_reset_i asynchronously mid-cycle -> all outputs 0 immediately, including overflow_o, with no completions after release.

Source files
------------

// File: rtl/math_wb_if.sv
// Result-collector bus: ALU channel A, math-unit channel B, and the merged
// register-file / ROB completion outputs.
interface math_wb_if;
    logic [31:0] a_result_i;
    logic [4:0]  a_rob_i;
    logic [5:0]  a_dest_i;
    logic        a_valid_i;
    logic        a_wb_valid_i;
    logic [31:0] b_result_i;
    logic [4:0]  b_rob_i;
    logic [5:0]  b_dest_i;
    logic        b_valid_i;
    logic        b_ready_o;
    logic        issue_stall_o;
    logic        overflow_o;
    logic        rf_wr_en_o;
    logic [5:0]  rf_wr_addr_o;
    logic [31:0] rf_wr_data_o;
    logic        rob_done_o;
    logic [4:0]  rob_id_o;

    modport slave (
        input  a_result_i, a_rob_i, a_dest_i, a_valid_i, a_wb_valid_i,
        input  b_result_i, b_rob_i, b_dest_i, b_valid_i,
        output b_ready_o, issue_stall_o, overflow_o,
        output rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, rob_done_o, rob_id_o
    );

    modport master (
        output a_result_i, a_rob_i, a_dest_i, a_valid_i, a_wb_valid_i,
        output b_result_i, b_rob_i, b_dest_i, b_valid_i,
        input  b_ready_o, issue_stall_o, overflow_o,
        input  rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, rob_done_o, rob_id_o
    );
endinterface

// File: rtl/math_wb_arbiter.sv
// Writeback collector: merges the non-stallable ALU stream (A, FIFO-buffered)
// with the valid/ready math-unit stream (B) onto one RF write / ROB completion port.
module math_wb_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned SKID       = 2,
    parameter int unsigned B_MAX_WAIT = 4
) (
    input  logic      core_clock_i,
    input  logic      core_reset_i,
    math_wb_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = $clog2(B_MAX_WAIT + 1);

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rob;
        logic [5:0]  dest;
        logic        wb;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            overflow_q, overflow_d;

    logic            rob_done_q, rob_done_d;
    logic            rf_wr_en_q, rf_wr_en_d;
    logic [5:0]      rf_wr_addr_q, rf_wr_addr_d;
    logic [31:0]     rf_wr_data_q, rf_wr_data_d;
    logic [4:0]      rob_id_q, rob_id_d;

    entry_t          a_in, b_in, a_sel, win;
    logic            fifo_empty, fifo_full;
    logic            a_cand, grant_a, grant_b;
    logic            enq, deq, do_write;

    // Arbitration, FIFO control and next-state for every register
    always_comb begin
        a_in         = {bus.a_result_i, bus.a_rob_i, bus.a_dest_i, bus.a_wb_valid_i};
        b_in         = {bus.b_result_i, bus.b_rob_i, bus.b_dest_i, (bus.b_dest_i != 6'd0)};
        fifo_empty   = (count_q == CW'(0));
        fifo_full    = (count_q == CW'(DEPTH));
        a_sel        = fifo_empty ? a_in : mem_q[rd_ptr_q];
        a_cand       = !fifo_empty || bus.a_valid_i;
        grant_b      = bus.b_valid_i && (!a_cand || (wait_q == WW'(B_MAX_WAIT)));
        grant_a      = a_cand && !grant_b;
        win          = grant_b ? b_in : a_sel;

        // Bypass only when empty keeps A completions in arrival order
        enq          = bus.a_valid_i && !(fifo_empty && grant_a);
        deq          = !fifo_empty && grant_a;
        do_write     = enq && (!fifo_full || deq);

        wr_ptr_d     = do_write ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = deq ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d      = count_q;
        if (do_write && !deq) begin
            count_d = count_q + CW'(1);
        end else if (!do_write && deq) begin
            count_d = count_q - CW'(1);
        end

        overflow_d   = overflow_q || (enq && fifo_full && !deq);

        wait_d       = wait_q;
        if (grant_b) begin
            wait_d = WW'(0);
        end else if (bus.b_valid_i && (wait_q != WW'(B_MAX_WAIT))) begin
            wait_d = wait_q + WW'(1);
        end

        rob_done_d   = grant_a || grant_b;
        rf_wr_en_d   = (grant_a || grant_b) && win.wb;
        rf_wr_addr_d = rf_wr_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        rob_id_d     = rob_id_q;
        if (grant_a || grant_b) begin
            rf_wr_addr_d = win.dest;
            rf_wr_data_d = win.result;
            rob_id_d     = win.rob;
        end
    end

    always_ff @(posedge core_clock_i or posedge core_reset_i) begin
        if (core_reset_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wait_q       <= '0;
            overflow_q   <= 1'b0;
            rob_done_q   <= 1'b0;
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
            rob_id_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wait_q       <= wait_d;
            overflow_q   <= overflow_d;
            rob_done_q   <= rob_done_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_wr_addr_q <= rf_wr_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            rob_id_q     <= rob_id_d;
        end
    end

    // Storage needs no reset: validity is tracked by the pointers and count
    always_ff @(posedge core_clock_i) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= a_in;
        end
    end

    assign bus.b_ready_o     = grant_b;
    assign bus.issue_stall_o = (count_q >= CW'(DEPTH - SKID));
    assign bus.overflow_o    = overflow_q;
    assign bus.rob_done_o    = rob_done_q;
    assign bus.rf_wr_en_o    = rf_wr_en_q;
    assign bus.rf_wr_addr_o  = rf_wr_addr_q;
    assign bus.rf_wr_data_o  = rf_wr_data_q;
    assign bus.rob_id_o      = rob_id_q;

endmodule

// File: tb/tb_math_wb_arbiter.sv
// Directed bench for math_wb_arbiter: expected completions are queued as
// stimulus is issued and a negedge monitor pops and compares each rob_done_o pulse.
module tb_math_wb_arbiter;

    typedef struct {
        logic [4:0]  rob;
        logic        wb;
        logic [5:0]  dest;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    math_wb_if bus();

    math_wb_arbiter #(.DEPTH(4), .SKID(2), .B_MAX_WAIT(4)) dut (
        .core_clock_i (clk),
        .core_reset_i (rst),
        .bus          (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic push_exp(input logic [4:0] rob, input logic wb, input logic [5:0] dest, input logic [31:0] data);
        exp_t e;
        e.rob  = rob;
        e.wb   = wb;
        e.dest = dest;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Standard A op: dest = rob+1, data tagged 0xA...; standard B op: dest = rob+32, data tagged 0xB...
    task automatic push_a(input int rob);
        push_exp(5'(rob), 1'b1, 6'(rob + 1), 32'hA000_0000 | 32'(rob));
    endtask

    task automatic push_b(input int rob);
        push_exp(5'(rob), 1'b1, 6'(rob + 32), 32'hB000_0000 | 32'(rob));
    endtask

    // One clock: drive inputs just after posedge, check combinational/sticky outputs at negedge
    task automatic cyc(input logic av, input logic [4:0] arob, input logic [5:0] adest,
                       input logic [31:0] adata, input logic awb,
                       input logic bv, input logic [4:0] brob, input logic [5:0] bdest,
                       input logic [31:0] bdata,
                       input logic eb, input logic es, input logic eo);
        bus.a_valid_i    = av;
        bus.a_rob_i      = arob;
        bus.a_dest_i     = adest;
        bus.a_result_i   = adata;
        bus.a_wb_valid_i = awb;
        bus.b_valid_i    = bv;
        bus.b_rob_i      = brob;
        bus.b_dest_i     = bdest;
        bus.b_result_i   = bdata;
        @(negedge clk);
        check("b_ready_o", 32'(bus.b_ready_o), 32'(eb));
        check("issue_stall_o", 32'(bus.issue_stall_o), 32'(es));
        check("overflow_o", 32'(bus.overflow_o), 32'(eo));
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_a(input logic av, input int arob, input logic bv, input int brob,
                         input logic eb, input logic es, input logic eo);
        cyc(av, 5'(arob), 6'(arob + 1), 32'hA000_0000 | 32'(arob), 1'b1,
            bv, 5'(brob), 6'(brob + 32), 32'hB000_0000 | 32'(brob), eb, es, eo);
    endtask

    task automatic idle(input int n, input logic es, input logic eo);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 5'd0, 6'd0, 32'd0, 1'b0, 1'b0, 5'd0, 6'd0, 32'd0, 1'b0, es, eo);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":rob_done_o"},    32'(bus.rob_done_o), 32'd0);
        check({tag, ":rf_wr_en_o"},    32'(bus.rf_wr_en_o), 32'd0);
        check({tag, ":rf_wr_addr_o"},  32'(bus.rf_wr_addr_o), 32'd0);
        check({tag, ":rf_wr_data_o"},  bus.rf_wr_data_o, 32'd0);
        check({tag, ":rob_id_o"},      32'(bus.rob_id_o), 32'd0);
        check({tag, ":overflow_o"},    32'(bus.overflow_o), 32'd0);
        check({tag, ":b_ready_o"},     32'(bus.b_ready_o), 32'd0);
        check({tag, ":issue_stall_o"}, 32'(bus.issue_stall_o), 32'd0);
    endtask

    // Completion monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.rob_done_o) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: got rob %0d, want none at %0t", bus.rob_id_o, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("rob_id_o", 32'(bus.rob_id_o), 32'(e.rob));
                        check("rf_wr_en_o", 32'(bus.rf_wr_en_o), 32'(e.wb));
                        if (e.wb) begin
                            check("rf_wr_addr_o", 32'(bus.rf_wr_addr_o), 32'(e.dest));
                            check("rf_wr_data_o", bus.rf_wr_data_o, e.data);
                        end
                    end
                end else begin
                    check("rf_wr_en_without_done", 32'(bus.rf_wr_en_o), 32'd0);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bus.a_valid_i = 1'b0; bus.a_rob_i = '0; bus.a_dest_i = '0; bus.a_result_i = '0; bus.a_wb_valid_i = 1'b0;
        bus.b_valid_i = 1'b0; bus.b_rob_i = '0; bus.b_dest_i = '0; bus.b_result_i = '0;
        #1 rst = 1'b1;
        #2 check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Single A op through the bypass
        push_exp(5'd3, 1'b1, 6'd5, 32'h0000_1234);
        cyc(1'b1, 5'd3, 6'd5, 32'h0000_1234, 1'b1, 1'b0, 5'd0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b0);

        // A op with no register write
        push_exp(5'd7, 1'b0, 6'd0, 32'd0);
        cyc(1'b1, 5'd7, 6'd0, 32'h0000_FFFF, 1'b0, 1'b0, 5'd0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b0);

        // B alone: accepted the same cycle
        push_exp(5'd2, 1'b1, 6'd9, 32'hDEAD_BEEF);
        cyc(1'b0, 5'd0, 6'd0, 32'd0, 1'b0, 1'b1, 5'd2, 6'd9, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b0);

        // Starvation guard: B refused 4 cycles, forced on the 5th, A keeps order
        for (int r = 10; r < 14; r++) push_a(r);
        push_b(20);
        push_a(14);
        push_a(15);
        for (int k = 0; k < 5; k++) cyc_a(1'b1, 10 + k, 1'b1, 20, (k == 4), 1'b0, 1'b0);
        cyc_a(1'b1, 15, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);

        // Fill to count 2 via two forced B wins, then drain
        for (int r = 0; r < 4; r++) push_a(r);
        push_b(16);
        for (int r = 4; r < 8; r++) push_a(r);
        push_b(17);
        push_a(8);
        push_a(9);
        for (int k = 0; k < 10; k++) cyc_a(1'b1, k, 1'b1, 16 + k / 5, (k % 5 == 4), 1'b0, 1'b0);
        idle(1, 1'b1, 1'b0);
        idle(2, 1'b0, 1'b0);

        // Preload to DEPTH, then overflow on the 5th forced B win; A24 is dropped
        for (int g = 0; g < 5; g++) begin
            for (int j = 0; j < 4; j++) push_a(4 * g + j);
            push_b(25 + g);
        end
        push_a(20);
        push_a(21);
        for (int k = 0; k < 25; k++) cyc_a(1'b1, k, 1'b1, 25 + k / 5, (k % 5 == 4), (k >= 10), 1'b0);
        idle(2, 1'b1, 1'b1);

        // Asynchronous reset mid-cycle while A22/A23 are still buffered
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
        idle(4, 1'b0, 1'b0);

        // Recovery after reset
        push_exp(5'd5, 1'b1, 6'd3, 32'h0000_0055);
        cyc(1'b1, 5'd5, 6'd3, 32'h0000_0055, 1'b1, 1'b0, 5'd0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
